// File: rtl/glb_token_arbiter_rr.sv
// glb_token_arbiter_rr: two-level round-robin GLB arbiter (class, then channel) with read-return tag pipeline.
// Optional saturating performance counters are enabled by defining GLB_ARB_PERF_CNT_EN.
`default_nettype none

module glb_token_arbiter_rr #(
    parameter int NCH    = 32,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1,
    localparam int IDW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                weight_load_state_i,
    input  logic [AW-1:0]       weight_addr_i,
    input  logic [NCH-1:0]      ifmap_read_req_i,
    input  logic [NCH*AW-1:0]   ifmap_read_addr_i,
    input  logic [NCH-1:0]      ipsum_read_req_i,
    input  logic [NCH*AW-1:0]   ipsum_read_addr_i,
    input  logic [NCH-1:0]      opsum_write_req_i,
    input  logic [NCH*AW-1:0]   opsum_write_addr_i,
    input  logic [NCH*4-1:0]    opsum_write_web_i,
    input  logic [NCH*DW-1:0]   opsum_write_data_i,
    output logic                glb_read_o,
    output logic                glb_write_o,
    output logic [AW-1:0]       glb_addr_o,
    output logic [3:0]          glb_web_o,
    output logic [DW-1:0]       glb_write_data_o,
    output logic [NCH-1:0]      permit_ifmap_o,
    output logic [NCH-1:0]      permit_ipsum_o,
    output logic [NCH-1:0]      permit_opsum_o,
    output logic                rdata_valid_o,
    output logic [1:0]          rdata_class_o,
    output logic [IDW-1:0]      rdata_id_o
`ifdef GLB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_read_cnt_o,
    output logic [31:0]         perf_write_cnt_o,
    output logic [31:0]         perf_conflict_cnt_o
`endif
);

    localparam logic [1:0] CLS_IFMAP  = 2'd0;
    localparam logic [1:0] CLS_IPSUM  = 2'd1;
    localparam logic [1:0] CLS_OPSUM  = 2'd2;
    localparam logic [1:0] CLS_WEIGHT = 2'd3;

    logic [1:0]     cls_ptr_q;
    logic [IDW-1:0] ch_ptr_q [3];
    logic [1:0]     tag_cls_q;
    logic [IDW-1:0] tag_id_q;

    logic [NCH-1:0] w_elig [3];
    logic [2:0]     w_cls_any;
    logic [IDW-1:0] w_ch_pick [3];
    logic [2:0]     w_cls_idx;
    logic           w_grant;
    logic [1:0]     w_cls;
    logic [IDW-1:0] w_ch;
    logic [IDW-1:0] w_ch_nxt;
    logic [NCH-1:0] w_onehot;
    logic [AW-1:0]  w_addr;
    logic [3:0]     w_web;
    logic [DW-1:0]  w_wdata;

    // Round-robin pick: lowest set bit at or above ptr, else lowest set bit overall.
    function automatic logic [IDW-1:0] f_rr_pick(input logic [NCH-1:0] v, input logic [IDW-1:0] ptr);
        logic [NCH-1:0] upper;
        logic [IDW-1:0] lo_all;
        logic [IDW-1:0] lo_up;
        upper  = '0;
        lo_all = '0;
        lo_up  = '0;
        for (int j = 0; j < NCH; j++) begin
            upper[j] = v[j] && (IDW'(j) >= ptr);
        end
        for (int j = NCH - 1; j >= 0; j--) begin
            if (v[j])     lo_all = IDW'(j);
            if (upper[j]) lo_up  = IDW'(j);
        end
        return (|upper) ? lo_up : lo_all;
    endfunction

    always_comb begin
        w_elig[0] = ifmap_read_req_i  & ~permit_ifmap_o;
        w_elig[1] = ipsum_read_req_i  & ~permit_ipsum_o;
        w_elig[2] = opsum_write_req_i & ~permit_opsum_o;
        for (int k = 0; k < 3; k++) begin
            w_cls_any[k] = |w_elig[k];
            w_ch_pick[k] = f_rr_pick(w_elig[k], ch_ptr_q[k]);
        end

        // Walk classes from the pointer; the last hit in reverse order is the first in rotation.
        w_grant   = 1'b0;
        w_cls     = cls_ptr_q;
        w_cls_idx = '0;
        for (int k = 2; k >= 0; k--) begin
            w_cls_idx = {1'b0, cls_ptr_q} + 3'(k);
            if (w_cls_idx >= 3'd3) w_cls_idx = w_cls_idx - 3'd3;
            if (w_cls_any[w_cls_idx[1:0]]) begin
                w_grant = 1'b1;
                w_cls   = w_cls_idx[1:0];
            end
        end

        w_ch     = w_ch_pick[w_cls];
        w_ch_nxt = (w_ch == IDW'(NCH - 1)) ? '0 : w_ch + 1'b1;
        w_onehot = NCH'(1) << w_ch;

        case (w_cls)
            CLS_IFMAP: w_addr = ifmap_read_addr_i[w_ch*AW +: AW];
            CLS_IPSUM: w_addr = ipsum_read_addr_i[w_ch*AW +: AW];
            default:   w_addr = opsum_write_addr_i[w_ch*AW +: AW];
        endcase
        w_web   = opsum_write_web_i[w_ch*4 +: 4];
        w_wdata = opsum_write_data_i[w_ch*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glb_read_o       <= 1'b0;
            glb_write_o      <= 1'b0;
            glb_addr_o       <= '0;
            glb_web_o        <= '0;
            glb_write_data_o <= '0;
            permit_ifmap_o   <= '0;
            permit_ipsum_o   <= '0;
            permit_opsum_o   <= '0;
            cls_ptr_q        <= CLS_IFMAP;
            for (int k = 0; k < 3; k++) ch_ptr_q[k] <= '0;
            tag_cls_q        <= '0;
            tag_id_q         <= '0;
        end else begin
            glb_read_o     <= 1'b0;
            glb_write_o    <= 1'b0;
            glb_web_o      <= '0;
            permit_ifmap_o <= '0;
            permit_ipsum_o <= '0;
            permit_opsum_o <= '0;
            tag_cls_q      <= '0;
            tag_id_q       <= '0;
            if (weight_load_state_i) begin
                glb_read_o <= 1'b1;
                glb_addr_o <= weight_addr_i;
                tag_cls_q  <= CLS_WEIGHT;
            end else if (w_grant) begin
                cls_ptr_q       <= (w_cls == CLS_OPSUM) ? CLS_IFMAP : w_cls + 2'd1;
                ch_ptr_q[w_cls] <= w_ch_nxt;
                glb_addr_o      <= w_addr;
                case (w_cls)
                    CLS_IFMAP: begin
                        glb_read_o     <= 1'b1;
                        permit_ifmap_o <= w_onehot;
                        tag_cls_q      <= CLS_IFMAP;
                        tag_id_q       <= w_ch;
                    end
                    CLS_IPSUM: begin
                        glb_read_o     <= 1'b1;
                        permit_ipsum_o <= w_onehot;
                        tag_cls_q      <= CLS_IPSUM;
                        tag_id_q       <= w_ch;
                    end
                    default: begin
                        glb_write_o      <= 1'b1;
                        glb_web_o        <= w_web;
                        glb_write_data_o <= w_wdata;
                        permit_opsum_o   <= w_onehot;
                    end
                endcase
            end
        end
    end

    // Tag pipeline: stage 0 captures the command cycle, so the last stage lines up with GLB read data.
    logic [RD_LAT-1:0] tv_q;
    logic [1:0]        tc_q [RD_LAT];
    logic [IDW-1:0]    ti_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tc_q[i] <= '0;
                ti_q[i] <= '0;
            end
        end else begin
            tv_q[0] <= glb_read_o;
            tc_q[0] <= tag_cls_q;
            ti_q[0] <= tag_id_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tv_q[i] <= tv_q[i-1];
                tc_q[i] <= tc_q[i-1];
                ti_q[i] <= ti_q[i-1];
            end
        end
    end

    assign rdata_valid_o = tv_q[RD_LAT-1];
    assign rdata_class_o = tc_q[RD_LAT-1];
    assign rdata_id_o    = ti_q[RD_LAT-1];

`ifdef GLB_ARB_PERF_CNT_EN
    logic w_conflict;
    assign w_conflict = (w_cls_any & (w_cls_any - 3'd1)) != 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_read_cnt_o     <= '0;
            perf_write_cnt_o    <= '0;
            perf_conflict_cnt_o <= '0;
        end else begin
            if (glb_read_o && (perf_read_cnt_o != 32'hFFFF_FFFF))
                perf_read_cnt_o <= perf_read_cnt_o + 32'd1;
            if (glb_write_o && (perf_write_cnt_o != 32'hFFFF_FFFF))
                perf_write_cnt_o <= perf_write_cnt_o + 32'd1;
            if (w_conflict && (perf_conflict_cnt_o != 32'hFFFF_FFFF))
                perf_conflict_cnt_o <= perf_conflict_cnt_o + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_glb_token_arbiter_rr.sv
// Randomized scoreboard bench for glb_token_arbiter_rr against a queue/array reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_glb_token_arbiter_rr;
    localparam int NCH    = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;
    localparam int IDW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           wl;
    logic [AW-1:0]  waddr;
    logic [NCH-1:0] req_v  [3];
    logic [AW-1:0]  addr_v [3][NCH];
    logic [3:0]     web_v  [NCH];
    logic [DW-1:0]  data_v [NCH];

    logic [NCH*AW-1:0] ifa, ipa, opa;
    logic [NCH*4-1:0]  opw;
    logic [NCH*DW-1:0] opd;

    always_comb begin
        ifa = '0; ipa = '0; opa = '0; opw = '0; opd = '0;
        for (int i = 0; i < NCH; i++) begin
            ifa[i*AW +: AW] = addr_v[0][i];
            ipa[i*AW +: AW] = addr_v[1][i];
            opa[i*AW +: AW] = addr_v[2][i];
            opw[i*4 +: 4]   = web_v[i];
            opd[i*DW +: DW] = data_v[i];
        end
    end

    logic           glb_read, glb_write;
    logic [AW-1:0]  glb_addr;
    logic [3:0]     glb_web;
    logic [DW-1:0]  glb_wdata;
    logic [NCH-1:0] p_if, p_ip, p_op;
    logic           rvalid;
    logic [1:0]     rclass;
    logic [IDW-1:0] rid;

    glb_token_arbiter_rr #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .weight_load_state_i (wl),
        .weight_addr_i       (waddr),
        .ifmap_read_req_i    (req_v[0]),
        .ifmap_read_addr_i   (ifa),
        .ipsum_read_req_i    (req_v[1]),
        .ipsum_read_addr_i   (ipa),
        .opsum_write_req_i   (req_v[2]),
        .opsum_write_addr_i  (opa),
        .opsum_write_web_i   (opw),
        .opsum_write_data_i  (opd),
        .glb_read_o          (glb_read),
        .glb_write_o         (glb_write),
        .glb_addr_o          (glb_addr),
        .glb_web_o           (glb_web),
        .glb_write_data_o    (glb_wdata),
        .permit_ifmap_o      (p_if),
        .permit_ipsum_o      (p_ip),
        .permit_opsum_o      (p_op),
        .rdata_valid_o       (rvalid),
        .rdata_class_o       (rclass),
        .rdata_id_o          (rid)
    );

    typedef struct packed {
        bit                  rd;
        bit                  wr;
        bit [AW-1:0]         addr;
        bit [3:0]            web;
        bit [DW-1:0]         data;
        bit [2:0][NCH-1:0]   perm;
        bit                  rv;
        bit [1:0]            rc;
        bit [IDW-1:0]        rid;
    } exp_t;

    typedef struct packed {
        bit           v;
        bit [1:0]     c;
        bit [IDW-1:0] id;
    } tag_t;

    exp_t sbq[$];
    tag_t tagq[$];
    exp_t cur, prev_e;
    int   cptr;
    int   chptr[3];
    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Reference: compute the output set the DUT should present after the next clock edge.
    task automatic model_step();
        exp_t n;
        tag_t t, t0;
        int   gc, gi, c, i;
        n      = '0;
        n.addr = cur.addr;
        n.data = cur.data;
        t      = '0;
        if (!rst_n) begin
            n    = '0;
            cptr = 0;
            for (int k = 0; k < 3; k++) chptr[k] = 0;
            tagq.delete();
            repeat (RD_LAT) tagq.push_back('0);
        end else begin
            if (wl) begin
                n.rd   = 1'b1;
                n.addr = waddr;
                t.v    = 1'b1;
                t.c    = 2'd3;
                t.id   = '0;
            end else begin
                gc = -1;
                gi = -1;
                for (int k = 0; k < 3; k++) begin
                    c = (cptr + k) % 3;
                    if (gc < 0)
                        for (int j = 0; j < NCH; j++)
                            if (req_v[c][j] && !cur.perm[c][j]) gc = c;
                end
                if (gc >= 0) begin
                    for (int k = 0; k < NCH; k++) begin
                        i = (chptr[gc] + k) % NCH;
                        if (gi < 0 && req_v[gc][i] && !cur.perm[gc][i]) gi = i;
                    end
                    chptr[gc]        = (gi + 1) % NCH;
                    cptr             = (gc + 1) % 3;
                    n.perm[gc][gi]   = 1'b1;
                    n.addr           = addr_v[gc][gi];
                    if (gc < 2) begin
                        n.rd = 1'b1;
                        t.v  = 1'b1;
                        t.c  = 2'(gc);
                        t.id = IDW'(gi);
                    end else begin
                        n.wr   = 1'b1;
                        n.web  = web_v[gi];
                        n.data = data_v[gi];
                    end
                end
            end
            t0    = tagq.pop_front();
            n.rv  = t0.v;
            n.rc  = t0.c;
            n.rid = t0.id;
            tagq.push_back(t);
        end
        sbq.push_back(n);
        prev_e = cur;
        cur    = n;
    endtask

    task automatic drive_requesters(input int prob);
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < NCH; i++) begin
                if (prev_e.perm[c][i]) begin
                    req_v[c][i] = 1'b0;
                end else if (!req_v[c][i] && ($urandom_range(99) < prob)) begin
                    req_v[c][i]  = 1'b1;
                    addr_v[c][i] = AW'($urandom);
                    if (c == 2) begin
                        web_v[i]  = 4'($urandom_range(1, 15));
                        data_v[i] = DW'($urandom);
                    end
                end
            end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("strobes", {62'd0, glb_read, glb_write}, {62'd0, e.rd, e.wr});
                    chk("glb_addr", 64'(glb_addr), 64'(e.addr));
                    chk("glb_web", 64'(glb_web), 64'(e.web));
                    chk("glb_wdata", 64'(glb_wdata), 64'(e.data));
                    chk("permits", 64'({p_op, p_ip, p_if}), 64'(e.perm));
                    chk("rdata_tag", 64'({rvalid, rclass, rid}), 64'({e.rv, e.rc, e.rid}));
                end
            end
        end
    end

    initial begin
        int prob;
        wl    = 1'b0;
        waddr = '0;
        cur   = '0;
        prev_e = '0;
        cptr  = 0;
        for (int c = 0; c < 3; c++) begin
            req_v[c] = '0;
            chptr[c] = 0;
            for (int i = 0; i < NCH; i++) addr_v[c][i] = '0;
        end
        for (int i = 0; i < NCH; i++) begin
            web_v[i]  = '0;
            data_v[i] = '0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            rst_n = !(cyc < 3 || (cyc >= 700 && cyc < 703));
            wl    = (cyc >= 400 && cyc < 430);
            waddr = (cyc < 410) ? AW'(16'h0100) : AW'($urandom);
            if (cyc < 400)       prob = 30;
            else if (cyc < 430)  prob = 60;
            else if (cyc < 700)  prob = 90;
            else if (cyc < 930)  prob = 45;
            else                 prob = 0;
            if (cyc >= 400 && cyc < 410) req_v[0] = '1;
            drive_requesters(prob);
            model_step();
            started = 1'b1;
        end
        @(posedge clk);
        #3;
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/glb_token_arbiter_rr.md
Name: glb_token_arbiter_rr

Overview:
Parametrised successor to the token-engine GLB arbiter. It arbitrates single-port GLB access among weight load, NCH ifmap read channels, NCH ipsum read channels and NCH opsum write channels. Arbitration is two-level round-robin: fair rotation across classes, then across channels within a class. A read-return tag pipeline tells the L3 FIFO controller which channel owns each GLB read datum.

Parameters:
NCH, 32, channels per class (ifmap/ipsum/opsum), 1..64
AW, 32, GLB address width
DW, 32, GLB data width
RD_LAT, 1, GLB read latency in cycles from glb_read_o to valid read data, 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
weight_load_state_i  in  1  weight-load phase; overrides all classes
weight_addr_i  in  AW  weight read address
ifmap_read_req_i  in  NCH  per-channel ifmap read request
ifmap_read_addr_i  in  NCH x AW  per-channel ifmap address
ipsum_read_req_i  in  NCH  per-channel ipsum read request
ipsum_read_addr_i  in  NCH x AW  per-channel ipsum address
opsum_write_req_i  in  NCH  per-channel opsum write request
opsum_write_addr_i  in  NCH x AW  per-channel opsum address
opsum_write_web_i  in  NCH x 4  per-channel byte write enables
opsum_write_data_i  in  NCH x DW  per-channel write data
glb_read_o  out  1  GLB read strobe
glb_write_o  out  1  GLB write strobe
glb_addr_o  out  AW  GLB address
glb_web_o  out  4  GLB byte write enable; 0 when not writing
glb_write_data_o  out  DW  GLB write data
permit_ifmap_o  out  NCH  one-hot grant, ifmap
permit_ipsum_o  out  NCH  one-hot grant, ipsum
permit_opsum_o  out  NCH  one-hot grant, opsum
rdata_valid_o  out  1  GLB read data valid this cycle
rdata_class_o  out  2  owner class of the returned datum: 0 ifmap, 1 ipsum, 3 weight
rdata_id_o  out  $clog2(NCH) (min 1)  owning channel index

Behaviour:
- Reset: every output is 0; class pointer = ifmap; all channel pointers = 0; tag pipeline cleared. Asserting reset mid-operation drops in-flight tags, and no rdata_valid_o is emitted afterwards for those reads.
- All outputs are registered. A grant decided in cycle t drives the permit and the GLB command together in cycle t+1. At most one permit bit, across all three vectors, is high in any cycle.
- Requesters hold req and addr until they see their permit. A channel whose permit is high in cycle t is masked from arbitration in cycle t, so no double grant occurs.
- weight_load_state_i=1: glb_read_o=1 and glb_addr_o=weight_addr_i every cycle. All permits are 0 and no pointer moves. A weight tag (class 3, id 0) enters the tag pipeline.
- Class level: classes with at least one eligible request compete. Search starts at the class pointer in the order ifmap→ipsum→opsum. After a grant, class pointer = granted class + 1 (mod 3).
- Channel level: within the granted class, pick the lowest index ≥ that class's pointer, wrapping. After the grant, pointer = index + 1 (mod NCH). Pointers of non-granted classes hold.
- Read grant: glb_read_o=1, glb_addr_o = the channel's address, glb_web_o=0, and the tag {class, id} enters the pipeline.
- Write grant: glb_write_o=1, glb_web_o = the channel's web, glb_write_data_o = the channel's data. No tag is pushed.
- No eligible request: strobes are 0, glb_web_o=0, and addr/data hold their previous values.
- Tag pipeline: RD_LAT stages. rdata_valid_o/class/id appear exactly RD_LAT cycles after the matching glb_read_o cycle; back-to-back reads produce back-to-back valids.
- NCH=1: channel pointer is constant 0; only class rotation applies.
- Full load (all 3·NCH requesting): each individual channel is granted once every 3·NCH cycles.

Optional Feature:
GLB_ARB_PERF_CNT_EN
- Defined: adds three 32-bit outputs: perf_read_cnt_o, perf_write_cnt_o, perf_conflict_cnt_o. The conflict counter increments in each cycle where more than one class has an eligible request. All three saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: rst_n low mid-stream with RD_LAT=2 → all outputs 0 next edge; no rdata_valid_o after release.
- Weight override: weight_load_state_i=1, weight_addr_i=0x100, all ifmap reqs high → glb_read_o=1, glb_addr_o=0x100, permits 0; rdata_class_o=3 after RD_LAT cycles.
- Channel RR: NCH=4, ifmap reqs 4'b1011 held → permit order ch0,ch1,ch3,ch0; each ifmap grant is a single-cycle pulse.
- Class RR: ifmap ch2, ipsum ch0 and opsum ch1 all requesting → grants ifmap, ipsum, opsum in consecutive grant cycles. The opsum grant drives glb_web_o=4'hF and glb_write_data_o = that channel's data.
- Tag return: RD_LAT=3, reads to ipsum ch5 then ifmap ch7 back-to-back → rdata_valid_o for 2 cycles starting 3 cycles later, tags (1,5) then (0,7).
- Idle/hold: all reqs drop after a grant → strobes 0, glb_web_o=0, glb_addr_o holds last value, pointers unchanged.
